// File: rtl/ex_alu_branch_unit_pkg.sv
// Shared constants for the EX-stage ALU/branch unit: datapath widths,
// ALU operation codes, branch opcodes and REGIMM rt sub-ops.
package ex_alu_branch_unit_pkg;

   localparam int W   = 32;
   localparam int OPW = 4;

   // ALU operation select
   localparam logic [OPW-1:0] ALU_ADD    = 4'b0000;
   localparam logic [OPW-1:0] ALU_SUB    = 4'b0001;
   localparam logic [OPW-1:0] ALU_AND    = 4'b0010;
   localparam logic [OPW-1:0] ALU_OR     = 4'b0011;
   localparam logic [OPW-1:0] ALU_XOR    = 4'b0100;
   localparam logic [OPW-1:0] ALU_NOR    = 4'b0101;
   localparam logic [OPW-1:0] ALU_SLL    = 4'b0110;
   localparam logic [OPW-1:0] ALU_SRL    = 4'b0111;
   localparam logic [OPW-1:0] ALU_SRA    = 4'b1000;
   localparam logic [OPW-1:0] ALU_SLT    = 4'b1001;
   localparam logic [OPW-1:0] ALU_SLTU   = 4'b1010;
   localparam logic [OPW-1:0] ALU_PASSA  = 4'b1011;
   localparam logic [OPW-1:0] ALU_PASSB  = 4'b1100;
   localparam logic [OPW-1:0] ALU_PASSB8 = 4'b1101;

   // instruction[31:26] branch opcodes
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   // REGIMM instruction[20:16] sub-ops
   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

endpackage

// File: rtl/ex_alu_branch_unit_if.sv
// EX-stage bus between the decode/forwarding side (master) and the
// ALU/branch unit (slave).
//  master drives: en, alu_op, a, b, pc_in, b_instr, opcode, rt
//  slave drives : alu_out, z, n, pc_plus4, branch_taken,
//                 alu_out_q, z_q, n_q, taken_q
interface ex_alu_branch_unit_if;
   import ex_alu_branch_unit_pkg::*;

   logic           en;
   logic [OPW-1:0] alu_op;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [W-1:0]   pc_in;
   logic           b_instr;
   logic [5:0]     opcode;
   logic [4:0]     rt;

   logic [W-1:0]   alu_out;
   logic           z;
   logic           n;
   logic [W-1:0]   pc_plus4;
   logic           branch_taken;
   logic [W-1:0]   alu_out_q;
   logic           z_q;
   logic           n_q;
   logic           taken_q;

   modport master (
      output en, alu_op, a, b, pc_in, b_instr, opcode, rt,
      input  alu_out, z, n, pc_plus4, branch_taken,
             alu_out_q, z_q, n_q, taken_q
   );

   modport slave (
      input  en, alu_op, a, b, pc_in, b_instr, opcode, rt,
      output alu_out, z, n, pc_plus4, branch_taken,
             alu_out_q, z_q, n_q, taken_q
   );
endinterface

// File: rtl/ex_alu_branch_unit_alu_core.sv
// Combinational 32-bit ALU with zero/negative flags.
//  alu_op_i  operation select
//  a_i, b_i  operands (shift amount from a_i[4:0], shifted value b_i)
//  alu_out_o result; z_o = result==0; n_o = result MSB
module ex_alu_branch_unit_alu_core
   import ex_alu_branch_unit_pkg::*;
(
   input  logic [OPW-1:0] alu_op_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [W-1:0]   alu_out_o,
   output logic           z_o,
   output logic           n_o
);

   logic [4:0] sh;
   assign sh = a_i[4:0];

   always_comb begin
      alu_out_o = '0;
      case (alu_op_i)
         ALU_ADD:    alu_out_o = a_i + b_i;
         ALU_SUB:    alu_out_o = a_i - b_i;
         ALU_AND:    alu_out_o = a_i & b_i;
         ALU_OR:     alu_out_o = a_i | b_i;
         ALU_XOR:    alu_out_o = a_i ^ b_i;
         ALU_NOR:    alu_out_o = ~(a_i | b_i);
         ALU_SLL:    alu_out_o = b_i << sh;
         ALU_SRL:    alu_out_o = b_i >> sh;
         ALU_SRA:    alu_out_o = $unsigned($signed(b_i) >>> sh);
         ALU_SLT:    alu_out_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_SLTU:   alu_out_o = {{(W-1){1'b0}}, (a_i < b_i)};
         ALU_PASSA:  alu_out_o = a_i;
         ALU_PASSB:  alu_out_o = b_i;
         ALU_PASSB8: alu_out_o = b_i + W'(8);
         default:    alu_out_o = '0;
      endcase
   end

   // flags follow the result for every op, SLT/SLTU included
   assign z_o = (alu_out_o == '0);
   assign n_o = alu_out_o[W-1];

endmodule

// File: rtl/ex_alu_branch_unit.sv
// EX-stage datapath core: ALU + flags, PC+4 incrementer, branch condition
// evaluator, and an EX/MEM register copy of result/flags/decision.
//  clk    clock
//  reset  synchronous active-low reset of the registered outputs
//  bus    ex_alu_branch_unit_if.slave (operands, controls, comb and _q results)
module ex_alu_branch_unit
   import ex_alu_branch_unit_pkg::*;
(
   input  logic clk,
   input  logic reset,
   ex_alu_branch_unit_if.slave bus
);

   logic [W-1:0] alu_res;
   logic         zf, nf, taken;

   ex_alu_branch_unit_alu_core u_alu (
      .alu_op_i  (bus.alu_op),
      .a_i       (bus.a),
      .b_i       (bus.b),
      .alu_out_o (alu_res),
      .z_o       (zf),
      .n_o       (nf)
   );

   assign bus.alu_out  = alu_res;
   assign bus.z        = zf;
   assign bus.n        = nf;
   assign bus.pc_plus4 = bus.pc_in + W'(4);

   // Decode steers the ALU to a-b on branches, so z/n compare rs against rt/zero.
   always_comb begin
      taken = 1'b0;
      if (bus.b_instr) begin
         case (bus.opcode)
            OP_BEQ:  taken = zf;
            OP_BNE:  taken = ~zf;
            OP_BLEZ: taken = zf | nf;
            OP_BGTZ: taken = ~zf & ~nf;
            OP_REGIMM: begin
               case (bus.rt)
                  RT_BLTZ, RT_BLTZAL: taken = nf;
                  RT_BGEZ, RT_BGEZAL: taken = ~nf;
                  default:            taken = 1'b0;
               endcase
            end
            default: taken = 1'b0;
         endcase
      end
   end
   assign bus.branch_taken = taken;

   // EX/MEM copy; en=0 holds across stalls, reset has priority
   logic [W-1:0] alu_q, alu_d;
   logic         zf_q, zf_d, nf_q, nf_d, tk_q, tk_d;

   always_comb begin
      alu_d = alu_q;
      zf_d  = zf_q;
      nf_d  = nf_q;
      tk_d  = tk_q;
      if (bus.en) begin
         alu_d = alu_res;
         zf_d  = zf;
         nf_d  = nf;
         tk_d  = taken;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         alu_q <= '0;
         zf_q  <= 1'b0;
         nf_q  <= 1'b0;
         tk_q  <= 1'b0;
      end else begin
         alu_q <= alu_d;
         zf_q  <= zf_d;
         nf_q  <= nf_d;
         tk_q  <= tk_d;
      end
   end

   assign bus.alu_out_q = alu_q;
   assign bus.z_q       = zf_q;
   assign bus.n_q       = nf_q;
   assign bus.taken_q   = tk_q;

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
module tb_ex_alu_branch_unit;
   import ex_alu_branch_unit_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_alu_branch_unit_if bus ();
   ex_alu_branch_unit dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      string       nm;
      logic        cc;           // compare combinational outputs
      logic [31:0] e_alu;
      logic        e_z, e_n, e_tk;
      logic [31:0] e_pc4;
      logic        cq;           // compare registered outputs
      logic [31:0] q_alu;
      logic        q_z, q_n, q_tk;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   checks = 0;
   int   errors = 0;

   task automatic ins(input logic [3:0] op, input logic [31:0] av, bv, pc,
                      input logic bi, input logic [5:0] opc, input logic [4:0] rtv,
                      input logic env);
      bus.alu_op  = op;
      bus.a       = av;
      bus.b       = bv;
      bus.pc_in   = pc;
      bus.b_instr = bi;
      bus.opcode  = opc;
      bus.rt      = rtv;
      bus.en      = env;
   endtask

   task automatic push(input string nm, input logic cc, input logic [31:0] ea,
                       input logic ez, en_, etk, input logic [31:0] epc,
                       input logic cq, input logic [31:0] qa, input logic qz, qn, qt);
      exp_t e;
      e.nm = nm; e.cc = cc; e.e_alu = ea; e.e_z = ez; e.e_n = en_; e.e_tk = etk;
      e.e_pc4 = epc; e.cq = cq; e.q_alu = qa; e.q_z = qz; e.q_n = qn; e.q_tk = qt;
      exp_q.push_back(e);
      -> sample_ev;
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   // monitor: pops one expectation per presented sample
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_underflow: got 0 entries expected 1");
         end else begin
            e = exp_q.pop_front();
            if (e.cc) begin
               cmp({e.nm, ".alu_out"}, bus.alu_out, e.e_alu);
               cmp({e.nm, ".z"}, {31'b0, bus.z}, {31'b0, e.e_z});
               cmp({e.nm, ".n"}, {31'b0, bus.n}, {31'b0, e.e_n});
               cmp({e.nm, ".taken"}, {31'b0, bus.branch_taken}, {31'b0, e.e_tk});
               cmp({e.nm, ".pc_plus4"}, bus.pc_plus4, e.e_pc4);
            end
            if (e.cq) begin
               cmp({e.nm, ".alu_out_q"}, bus.alu_out_q, e.q_alu);
               cmp({e.nm, ".z_q"}, {31'b0, bus.z_q}, {31'b0, e.q_z});
               cmp({e.nm, ".n_q"}, {31'b0, bus.n_q}, {31'b0, e.q_n});
               cmp({e.nm, ".taken_q"}, {31'b0, bus.taken_q}, {31'b0, e.q_tk});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      ins(ALU_ADD, 32'd9, 32'd9, 32'h0, 1'b0, 6'h0, 5'h0, 1'b1);
      repeat (2) @(negedge clk);
      // reset holds q at zero even with en=1 and a nonzero result
      push("reset", 1'b0, 0, 0, 0, 0, 0, 1'b1, 32'h0, 0, 0, 0);
      @(negedge clk); reset = 1'b1;

      @(negedge clk);
      ins(ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h10, 1'b0, 6'h0, 5'h0, 1'b1);
      push("add_ovf", 1'b1, 32'h80000000, 0, 1, 0, 32'h14, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'd5, 32'd5, 32'hFFFFFFFC, 1'b0, 6'h0, 5'h0, 1'b1);
      push("sub_zero", 1'b1, 32'h0, 1, 0, 0, 32'h0, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SRA, 32'd4, 32'h80000000, 32'h100, 1'b0, 6'h0, 5'h0, 1'b1);
      push("sra", 1'b1, 32'hF8000000, 0, 1, 0, 32'h104, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SRL, 32'd4, 32'h80000000, 32'h100, 1'b0, 6'h0, 5'h0, 1'b1);
      push("srl", 1'b1, 32'h08000000, 0, 0, 0, 32'h104, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SLL, 32'd8, 32'h00F0000F, 32'h0, 1'b0, 6'h0, 5'h0, 1'b1);
      push("sll", 1'b1, 32'hF0000F00, 0, 1, 0, 32'h4, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 6'h0, 5'h0, 1'b1);
      push("slt", 1'b1, 32'h1, 0, 0, 0, 32'h4, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 6'h0, 5'h0, 1'b1);
      push("sltu", 1'b1, 32'h0, 1, 0, 0, 32'h4, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_NOR, 32'h0F0F0000, 32'h000000FF, 32'h0, 1'b0, 6'h0, 5'h0, 1'b1);
      push("nor", 1'b1, 32'hF0F0FF00, 0, 1, 0, 32'h4, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_XOR, 32'hFFFF0000, 32'hFF00FF00, 32'h0, 1'b0, 6'h0, 5'h0, 1'b1);
      push("xor", 1'b1, 32'h00FFFF00, 0, 0, 0, 32'h4, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_PASSB8, 32'h0, 32'h00400010, 32'h0, 1'b0, 6'h0, 5'h0, 1'b1);
      push("passb8", 1'b1, 32'h00400018, 0, 0, 0, 32'h4, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(4'b1110, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0, 6'h0, 5'h0, 1'b1);
      push("op1110", 1'b1, 32'h0, 1, 0, 0, 32'h4, 1'b0, 0, 0, 0, 0);

      // branches: ALU set to a-b
      @(negedge clk);
      ins(ALU_SUB, 32'd3, 32'd0, 32'h40, 1'b1, OP_BGTZ, 5'h0, 1'b1);
      push("bgtz_pos", 1'b1, 32'd3, 0, 0, 1, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'd0, 32'd0, 32'h40, 1'b1, OP_BGTZ, 5'h0, 1'b1);
      push("bgtz_zero", 1'b1, 32'd0, 1, 0, 0, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'd4, 32'd4, 32'h40, 1'b0, OP_BEQ, 5'h0, 1'b1);
      push("beq_noinstr", 1'b1, 32'd0, 1, 0, 0, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'd4, 32'd4, 32'h40, 1'b1, OP_BEQ, 5'h0, 1'b1);
      push("beq_eq", 1'b1, 32'd0, 1, 0, 1, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'd4, 32'd4, 32'h40, 1'b1, OP_BNE, 5'h0, 1'b1);
      push("bne_eq", 1'b1, 32'd0, 1, 0, 0, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'd1, 32'd3, 32'h40, 1'b1, OP_BLEZ, 5'h0, 1'b1);
      push("blez_neg", 1'b1, 32'hFFFFFFFE, 0, 1, 1, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'hFFFFFFFE, 32'd0, 32'h40, 1'b1, OP_REGIMM, RT_BGEZ, 1'b1);
      push("bgez_neg", 1'b1, 32'hFFFFFFFE, 0, 1, 0, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'hFFFFFFFE, 32'd0, 32'h40, 1'b1, OP_REGIMM, RT_BLTZAL, 1'b1);
      push("bltzal_neg", 1'b1, 32'hFFFFFFFE, 0, 1, 1, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'd7, 32'd0, 32'h40, 1'b1, OP_REGIMM, RT_BGEZAL, 1'b1);
      push("bgezal_pos", 1'b1, 32'd7, 0, 0, 1, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'hFFFFFFFE, 32'd0, 32'h40, 1'b1, OP_REGIMM, 5'b00010, 1'b1);
      push("regimm_bad_rt", 1'b1, 32'hFFFFFFFE, 0, 1, 0, 32'h44, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_SUB, 32'd4, 32'd4, 32'h40, 1'b1, 6'b000010, 5'h0, 1'b1);
      push("bad_opcode", 1'b1, 32'd0, 1, 0, 0, 32'h44, 1'b0, 0, 0, 0, 0);

      // registered path: load, then stall
      @(negedge clk);
      ins(ALU_ADD, 32'd2, 32'd3, 32'h80, 1'b0, 6'h0, 5'h0, 1'b1);
      push("load_add", 1'b1, 32'd5, 0, 0, 0, 32'h84, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      ins(ALU_AND, 32'hF0, 32'h0F, 32'h80, 1'b0, 6'h0, 5'h0, 1'b0);
      push("loaded", 1'b1, 32'd0, 1, 0, 0, 32'h84, 1'b1, 32'd5, 0, 0, 0);
      @(negedge clk);
      ins(ALU_OR, 32'h80000000, 32'h1, 32'h80, 1'b1, OP_BLEZ, 5'h0, 1'b0);
      push("stall_hold", 1'b1, 32'h80000001, 0, 1, 1, 32'h84, 1'b1, 32'd5, 0, 0, 0);

      // reset beats en, then resumes
      @(negedge clk);
      reset = 1'b0;
      ins(ALU_SUB, 32'd3, 32'd0, 32'h80, 1'b1, OP_BGTZ, 5'h0, 1'b1);
      push("pre_rst", 1'b0, 0, 0, 0, 0, 0, 1'b1, 32'd5, 0, 0, 0);
      @(negedge clk);
      push("in_rst", 1'b0, 0, 0, 0, 0, 0, 1'b1, 32'd0, 0, 0, 0);
      reset = 1'b1;
      @(negedge clk);
      push("resume", 1'b1, 32'd3, 0, 0, 1, 32'h84, 1'b1, 32'd3, 0, 0, 1);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
